// File: rtl/rd_control.sv
// Read-side staggered wavefront generator for one memArr bank feeding the systolic array.
// Optional stall gating is enabled by defining RD_CONTROL_STALL_EN.
module rd_control #(
  parameter int unsigned width_height = 16,
  parameter int unsigned addr_width   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 active,
`ifdef RD_CONTROL_STALL_EN
  input  logic                                 stall,
`endif
  output logic [width_height-1:0]              rd_en,
  output logic [addr_width*width_height-1:0]   rd_addr,
  output logic                                 busy,
  output logic                                 done
);

  localparam logic [width_height-1:0] LaneOne = width_height'(1);
  localparam logic [addr_width-1:0]   AddrOne = addr_width'(1);

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  state_e                              r_state, w_state_d;
  logic [width_height-1:0]             r_en, w_en_d;
  logic [addr_width*width_height-1:0]  r_addr, w_addr_d;
  logic                                r_busy, w_busy_d;
  logic                                r_done, w_done_d;
  logic                                w_stall;

`ifdef RD_CONTROL_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_en    <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_en    <= w_en_d;
      r_addr  <= w_addr_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_en_d    = r_en;
    w_addr_d  = r_addr;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;

    // Lanes enabled this cycle step to their next row.
    if ((r_state != StIdle) && !w_stall) begin
      for (int i = 0; i < int'(width_height); i++) begin
        if (r_en[i]) begin
          w_addr_d[addr_width*i +: addr_width] = r_addr[addr_width*i +: addr_width] + AddrOne;
        end
      end
    end

    unique case (r_state)
      StIdle: begin
        w_en_d   = '0;
        w_addr_d = '0;
        w_busy_d = 1'b0;
        if (active) begin
          w_en_d    = LaneOne;
          w_busy_d  = 1'b1;
          // A single-lane array is already full on the start edge.
          w_state_d = (width_height == 1) ? StDrain : StFill;
        end
      end
      StFill: begin
        if (!w_stall) begin
          w_en_d = (r_en << 1) | LaneOne;
          if (&w_en_d) w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (!w_stall) begin
          w_en_d = r_en << 1;
          if (w_en_d == '0) begin
            w_state_d = StIdle;
            w_addr_d  = '0;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_en_d    = '0;
        w_addr_d  = '0;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  // Stall masks the enables only; addresses and busy stay visible.
  assign rd_en   = w_stall ? '0 : r_en;
  assign rd_addr = r_addr;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_rd_control.sv
// Directed self-checking bench for rd_control; covers the stall path when
// RD_CONTROL_STALL_EN is defined.
module tb_rd_control;

  localparam int W  = 16;
  localparam int AW = 8;

  logic            clk;
  logic            reset;
  logic            active;
  logic            stall;
  logic [W-1:0]    rd_en;
  logic [AW*W-1:0] rd_addr;
  logic            busy;
  logic            done;

  int n_total = 0;
  int n_bad   = 0;

  rd_control #(
    .width_height(W),
    .addr_width  (AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .active (active),
`ifdef RD_CONTROL_STALL_EN
    .stall  (stall),
`endif
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Lane i is enabled in cycles i..i+W-1 of a sweep.
  function automatic logic [W-1:0] exp_en(input int c);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) if (c >= i && c <= i + W - 1) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " rd_en"}, rd_en, 0);
    check({tag, " addr"}, rd_addr, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
  endtask

  task automatic check_cycle(input int c);
    logic [W-1:0] m;
    m = exp_en(c);
    check($sformatf("c%0d rd_en", c), rd_en, m);
    check($sformatf("c%0d busy", c), busy, 1);
    check($sformatf("c%0d done", c), done, 0);
    for (int i = 0; i < W; i++) begin
      if (m[i]) check($sformatf("c%0d addr%0d", c, i), rd_addr[AW*i +: AW], c - i);
    end
  endtask

  // mode 0: single pulse, 1: toggling active during sweep, 2: active held high
  task automatic sweep(input int mode);
    active = 1'b1;
    tick();
    active = (mode == 2);
    for (int c = 0; c < 2 * W - 1; c++) begin
      check_cycle(c);
      if (mode == 1) active = c[0];
      else           active = (mode == 2);
      tick();
    end
    check($sformatf("m%0d done pulse", mode), done, 1);
    check($sformatf("m%0d done busy", mode), busy, 0);
    check($sformatf("m%0d done rd_en", mode), rd_en, 0);
    check($sformatf("m%0d done addr", mode), rd_addr, 0);
    active = (mode == 2);
    tick();
    check($sformatf("m%0d c32 rd_en", mode), rd_en, (mode == 2) ? 1 : 0);
    check($sformatf("m%0d c32 busy", mode), busy, (mode == 2) ? 1 : 0);
    check($sformatf("m%0d c32 done", mode), done, 0);
    check($sformatf("m%0d c32 addr", mode), rd_addr, 0);
    active = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    int cyc;
    reset  = 1'b0;
    active = 1'b0;
    stall  = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    check_idle("in reset");
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_idle($sformatf("idle%0d", k));
    end

    sweep(0);
    sweep(1);
    sweep(2);
    do_reset();
    check_idle("after b2b reset");

    // Abort a sweep in DRAIN.
    active = 1'b1;
    tick();
    active = 1'b0;
    repeat (20) tick();
    check("mid c20 rd_en", rd_en, 16'hFFE0);
    reset = 1'b0;
    tick();
    check_idle("mid abort");
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_idle($sformatf("post abort%0d", k));
    end
    active = 1'b1;
    tick();
    active = 1'b0;
    check("restart rd_en", rd_en, 1);
    check("restart busy", busy, 1);
    check("restart addr", rd_addr, 0);
    do_reset();

    // Reset beats a simultaneous start request.
    reset  = 1'b0;
    active = 1'b1;
    tick();
    check("prec rd_en", rd_en, 0);
    check("prec busy", busy, 0);
    reset  = 1'b1;
    active = 1'b0;
    tick();
    check_idle("prec after");

`ifdef RD_CONTROL_STALL_EN
    // Stall high during cycles 5..7 holds edges 6, 7 and 8.
    active = 1'b1;
    tick();
    active = 1'b0;
    repeat (4) tick();
    @(posedge clk);
    #1 stall = 1'b1;
    @(negedge clk);
    check("stall c5 rd_en", rd_en, 0);
    check("stall c5 busy", busy, 1);
    check("stall c5 addr0", rd_addr[AW-1:0], 5);
    tick();
    tick();
    check("stall c7 rd_en", rd_en, 0);
    @(posedge clk);
    #1 stall = 1'b0;
    @(negedge clk);
    check("stall c8 rd_en", rd_en, 16'h003F);
    check("stall c8 addr0", rd_addr[AW-1:0], 5);
    cyc = 8;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
    check("stall done cycle", cyc, 34);
    tick();
    check_idle("stall after");
`else
    cyc = 0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rd_control.md
Name: rd_control

Overview:
- Read-side address/enable generator for one memArr bank (weight or input buffer) feeding the systolic array.
- On an active request it produces the staggered diagonal read wavefront:
  - lane i reads rows 0..width_height-1, starting i cycles after lane 0;
  - data therefore enters the array skewed.
- Counterpart to the write controller that fills the same memory; per-lane address offsets are added to a base address outside this block.

Parameters:
- width_height, 16, number of lanes (memory columns / array rows); also the number of rows read per lane.
- addr_width, 8, per-lane address offset width; rd_addr packs width_height fields of addr_width bits each.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- active  input  1  start request, sampled only in IDLE.
- rd_en  output  width_height  per-lane read enable; bit i = lane i.
- rd_addr  output  addr_width*width_height  packed per-lane read offsets; lane i = bits [addr_width*i +: addr_width].
- busy  output  1  high while a sweep is in progress (FILL or DRAIN).
- done  output  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (reset==0 at an edge):
  - next state IDLE; rd_en=0, rd_addr=0, busy=0, done=0.
  - Reset overrides all other inputs, including mid-sweep; no done is generated for an aborted sweep.
- All outputs are registered except the optional stall gating below.
- States are IDLE, FILL and DRAIN.
  - IDLE:
    - rd_en=0, all rd_addr fields=0, busy=0.
    - active==1 at an edge -> FILL; the same edge loads rd_en=1 (lane 0 only); busy=1.
  - FILL: each edge, rd_en <= (rd_en<<1)|1. When rd_en becomes all ones, the state moves to DRAIN on that same edge.
  - DRAIN:
    - each edge, rd_en <= rd_en<<1.
    - the edge on which rd_en becomes 0 moves the state to IDLE, sets done=1 for one cycle, clears busy, and zeroes all rd_addr fields.
- Address update (FILL/DRAIN): each edge, every lane whose rd_en bit is currently 1 increments its rd_addr field by 1. All other lanes hold.
  - The field value visible while a lane is enabled is therefore the row being read: 0,1,..,width_height-1.
  - Arithmetic wraps modulo 2^addr_width; this cannot occur when width_height <= 2^addr_width.
- Timing, start edge = cycle 0:
  - lane i is enabled in cycles i..i+width_height-1;
  - rd_en is nonzero for exactly 2*width_height-1 consecutive cycles;
  - done is asserted in cycle 2*width_height-1.
- active while busy is ignored (no queueing). active held high continuously starts a new sweep on the first edge after done, i.e. the edge where the state is IDLE.
- Simultaneous events:
  - reset low together with active high -> reset wins.
  - done cycle with active high -> sweep restarts on the following edge, not the done edge.

Optional Feature:
- Macro RD_CONTROL_STALL_EN.
- Defined:
  - adds input port stall (1 bit), listed after active.
  - While stall==1 at an edge, the state, rd_en register, rd_addr and the FILL/DRAIN progress all hold.
  - rd_en output is combinationally forced to 0 while stall==1, so no memory read occurs; rd_addr and busy are unaffected.
  - The sweep resumes exactly where it paused once stall drops.
  - Stall in IDLE has no effect, and active is still accepted.
  - Reset overrides stall.
- Undefined: no stall port; behaviour exactly as above.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, keep active=0 for 10 cycles -> rd_en=16'h0000, rd_addr=0, busy=0, done=0 throughout.
- Full sweep, width_height=16: pulse active in cycle 0 ->
  - rd_en follows 0001,0003,..,FFFF (cycle 15),FFFE,..,8000 (cycle 30), then 0000;
  - lane 0 addr 0..15 in cycles 0..15; lane 15 addr 0..15 in cycles 15..30;
  - done=1 only in cycle 31; busy=1 in cycles 0..30.
- Back-to-back: hold active=1 continuously -> second sweep starts at cycle 32 with rd_en=0001 and all addresses 0; active pulses during cycles 1..30 are ignored.
- Mid-sweep reset: reset=0 at cycle 20 (DRAIN, rd_en=FFE0) -> next cycle rd_en=0, rd_addr=0, busy=0, no done pulse; a fresh active starts cleanly.
- Reset precedence: reset=0 and active=1 on the same edge -> remains IDLE, rd_en=0.
- With RD_CONTROL_STALL_EN: assert stall for cycles 5..7 of a sweep ->
  - rd_en=0 in cycles 5..7;
  - cycle 8 shows rd_en=003F with lane 0 addr 5;
  - done is delayed by exactly 3 cycles, arriving in cycle 34.
